imem_loader: RTL and testbench
==============================

# imem_loader

Instruction-memory boot loader and port arbiter for the single-cycle MIPS core. On request, it halts the CPU and receives a length-prefixed program image as a byte stream from the UART receiver. It packs the bytes into big-endian 32-bit words, writes them into the instruction RAM, then restarts the CPU at PC 0. The block owns the single instruction-memory address port. The address comes from the CPU fetch path while the CPU runs, and from the loader while a load is in progress.

## Interface
- `DEPTH`, default 256: instruction memory size in words.
- `ADDR_W`, default `$clog2(DEPTH)`: word-address width.
- `TIMEOUT_CYC`, default 1_000_000: maximum idle cycles between bytes inside a frame.
- `clk` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `load_req` in 1: one-cycle request to start or restart a load.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: `rx_data` is valid this cycle; a single-cycle strobe.
- `cpu_addr` in ADDR_W: CPU fetch word address (PC[ADDR_W+1:2]).
- `imem_addr` out ADDR_W: instruction memory word address.
- `imem_we` out 1: instruction memory write enable.
- `imem_wdata` out 32: instruction memory write data.
- `cpu_hold` out 1: stalls the CPU and gates PC updates.
- `cpu_restart` out 1: one-cycle pulse that forces PC to 0.
- `busy` out 1: a load is in progress.
- `error` out 1: the last load failed; sticky until the next `load_req`.
- `words_loaded` out ADDR_W+1: number of words written by the current or last load.

## Operation
- States: RUN, LEN_HI, LEN_LO, DATA, CHK (only when the checksum feature is compiled in), DONE, ERR.
- Reset behaviour:
  - State goes to RUN.
  - All outputs are 0, except `imem_addr`, which equals `cpu_addr`.
  - Byte and pointer counters clear.
- RUN:
  - `load_req` moves to LEN_HI.
  - `rx_valid` is ignored.
- `load_req` in any non-RUN state also moves to LEN_HI. The load restarts: pointer, byte count and `words_loaded` clear, and `error` clears.
- `load_req` takes priority over a simultaneous `rx_valid`; that byte is dropped.
- LEN_HI:
  - The first byte is the length high byte; the next state is LEN_LO.
  - There is no timeout in this state.
- LEN_LO:
  - The second byte completes the 16-bit word count N.
  - If N > DEPTH, go to ERR.
  - If N = 0, go to CHK or DONE.
  - Otherwise go to DATA.
- DATA:
  - Bytes are packed most significant byte first.
  - On the 4th byte of a word, `imem_we` is 1 in the following cycle, with `imem_addr` = pointer and `imem_wdata` = the packed word.
  - After the write, the pointer and `words_loaded` increment.
  - After the N-th word is written, go to CHK or DONE.
- DONE: lasts exactly one cycle. `cpu_restart` = 1 and `cpu_hold` = 1; the next state is RUN.
- ERR: `cpu_hold` stays 1 and `error` = 1 until `load_req` arrives. Memory contents are left partially written.
- Timeout: in LEN_LO, DATA and CHK, an idle counter clears on every `rx_valid`. When the counter reaches TIMEOUT_CYC, go to ERR.
- `cpu_hold` = `busy` = 1 in LEN_HI, LEN_LO, DATA and CHK.
- Address mux: `imem_addr` = loader pointer whenever `cpu_hold` is 1; otherwise `imem_addr` = `cpu_addr`. This path is combinational.

## Timing
- From `load_req` to `cpu_hold` = 1: 1 cycle, because `cpu_hold` is registered.
- From the 4th byte's `rx_valid` to `imem_we`: 1 cycle. The address and data are stable during that cycle.
- Minimum byte spacing: 1 cycle. Back-to-back `rx_valid` is legal, and the final write may coincide with the next byte's arrival.
- From the last write to `cpu_restart`: 1 cycle. `cpu_hold` falls in the cycle after `cpu_restart`.
- Reset mid-frame: the load aborts immediately, no further writes occur, and the CPU runs from the existing memory contents.

## Configuration
- Macro: `IMEM_LOADER_CHECKSUM_EN`.
- Defined:
  - One extra byte follows the data: the XOR of all data bytes (length bytes excluded).
  - The CHK state compares it with the running XOR. A match goes to DONE; a mismatch goes to ERR.
  - The checksum is also required when N = 0; its expected value is 0x00.
- Undefined: the CHK state and the XOR register do not exist, and the state after the last write is DONE.

## Structure
- Package `imem_loader_pkg`:
  - The state enum.
  - Byte-lane index type (2 bits).
  - Length field width constant (16).
- Sub-module `imem_word_packer`:
  - Shift register and 2-bit lane counter.
  - `clear` input.
  - `word_valid` output, a one-cycle pulse.
  - 32-bit `word` output.
  - Running XOR, present only under the macro.

## Test plan
- Reset with `cpu_addr` = 5 -> RUN, `cpu_hold` = 0, `imem_addr` = 5, `imem_we` = 0, `error` = 0.
- Send `load_req` then bytes 00 02 12 34 56 78 9A BC DE F0 (under the macro, add checksum 00) -> expect:
  - Writes of 0x12345678 at address 0 and 0x9ABCDEF0 at address 1.
  - One `cpu_restart` pulse.
  - `words_loaded` = 2, then `cpu_hold` = 0.
- With DEPTH = 256, send length 01 01 -> ERR after the second byte, no writes, `cpu_hold` = 1. A subsequent `load_req` and a valid frame succeed.
- With TIMEOUT_CYC = 100, send 00 01 12 and then idle 100 cycles -> `error` = 1, no write. A byte sent afterwards is ignored.
- With the macro defined, send the frame from scenario 2 but a checksum of 01 -> ERR, no `cpu_restart`. With checksum 00 -> DONE.
- Assert `reset` after 6 data bytes -> `imem_we` never rises again, outputs return to reset values, and `imem_addr` tracks `cpu_addr`.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory boot loader.
// Optional checksum byte support is enabled with the macro IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

    // Width of the big-endian word-count field at the head of every frame
    localparam int LEN_W = 16;

    // Byte position inside the 32-bit word currently being assembled
    typedef logic [1:0] lane_t;

    // Loader states; CHK only exists when the trailing checksum byte is expected
    typedef enum logic [2:0] {
        RUN,
        LEN_HI,
        LEN_LO,
        DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK,
`endif
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/imem_word_packer.sv
// Packs a byte stream into big-endian 32-bit words.
// With IMEM_LOADER_CHECKSUM_EN defined it also keeps a running XOR of every byte.
module imem_word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        word_valid,
    output logic [31:0] word
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic [7:0]  xor_sum
`endif
);
    import imem_loader_pkg::*;

    logic [23:0] r_shift;
    lane_t       r_lane;
    logic        r_wordValid;
    logic [31:0] r_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  r_xor;
`endif

    // Shift bytes in MSB first; the fourth byte publishes the word for exactly one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift     <= '0;
            r_lane      <= '0;
            r_wordValid <= 1'b0;
            r_word      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor       <= '0;
`endif
        end else if (clear) begin
            r_shift     <= '0;
            r_lane      <= '0;
            r_wordValid <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor       <= '0;
`endif
        end else begin
            r_wordValid <= 1'b0;
            if (in_valid) begin
                r_shift <= {r_shift[15:0], in_data};
                r_lane  <= r_lane + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_xor   <= r_xor ^ in_data;
`endif
                if (r_lane == 2'd3) begin
                    r_wordValid <= 1'b1;
                    r_word      <= {r_shift, in_data};
                end
            end
        end
    end

    assign word_valid = r_wordValid;
    assign word       = r_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign xor_sum    = r_xor;
`endif

endmodule

// File: rtl/imem_loader.sv
// Boot loader and address-port arbiter for the instruction RAM.
// Halts the CPU, receives a length-prefixed image over the UART byte stream,
// writes it word by word and restarts the CPU at PC 0.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = $clog2(DEPTH),
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_we,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              cpu_restart,
    output logic              busy,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);
    import imem_loader_pkg::*;

    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

    state_t              r_state;
    logic                r_cpuHold;
    logic                r_cpuRestart;
    logic                r_busy;
    logic                r_error;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W:0]     r_wordsLoaded;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W+1:0]    r_byteCnt;
    logic [IDLE_W-1:0]   r_idle;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic                r_chkHave;
    logic [7:0]          r_chkByte;
    logic [7:0]          w_xor;
    logic [7:0]          w_chkByte;
`endif

    logic [LEN_W-1:0]    w_n;
    logic                w_dataByte;
    logic                w_wordValid;
    logic [31:0]         w_word;
    logic [ADDR_W:0]     w_nextCount;
    logic                w_lastWord;
    logic                w_counting;
    logic                w_timeout;

    assign w_n         = {r_len[LEN_W-1:8], rx_data};
    assign w_dataByte  = (r_state == DATA) && rx_valid && !load_req &&
                         (r_byteCnt != {r_len, 2'b00});
    assign w_nextCount = r_wordsLoaded + (ADDR_W + 1)'(1);
    assign w_lastWord  = (LEN_W'(w_nextCount) == r_len);
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign w_counting  = (r_state == LEN_LO) || (r_state == DATA) || (r_state == CHK);
    assign w_chkByte   = r_chkHave ? r_chkByte : rx_data;
`else
    assign w_counting  = (r_state == LEN_LO) || (r_state == DATA);
`endif
    assign w_timeout   = w_counting && !rx_valid && (r_idle == IDLE_W'(TIMEOUT_CYC - 1));

    imem_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (load_req),
        .in_valid   (w_dataByte),
        .in_data    (rx_data),
        .word_valid (w_wordValid),
        .word       (w_word)
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        .xor_sum    (w_xor)
`endif
    );

    // Frame-parsing FSM with registered hold/restart/busy/error and write bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= RUN;
            r_cpuHold     <= 1'b0;
            r_cpuRestart  <= 1'b0;
            r_busy        <= 1'b0;
            r_error       <= 1'b0;
            r_ptr         <= '0;
            r_wordsLoaded <= '0;
            r_len         <= '0;
            r_byteCnt     <= '0;
            r_idle        <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_chkHave     <= 1'b0;
            r_chkByte     <= '0;
`endif
        end else begin
            r_cpuRestart <= 1'b0;

            if (load_req || rx_valid || !w_counting) begin
                r_idle <= '0;
            end else begin
                r_idle <= r_idle + IDLE_W'(1);
            end

            if (w_wordValid) begin
                r_ptr         <= r_ptr + ADDR_W'(1);
                r_wordsLoaded <= w_nextCount;
            end

            if (load_req) begin
                r_state       <= LEN_HI;
                r_cpuHold     <= 1'b1;
                r_busy        <= 1'b1;
                r_error       <= 1'b0;
                r_ptr         <= '0;
                r_wordsLoaded <= '0;
                r_byteCnt     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_chkHave     <= 1'b0;
`endif
            end else begin
                case (r_state)
                    RUN: begin
                    end
                    LEN_HI: begin
                        if (rx_valid) begin
                            r_len[LEN_W-1:8] <= rx_data;
                            r_state          <= LEN_LO;
                        end
                    end
                    LEN_LO: begin
                        if (rx_valid) begin
                            r_len <= w_n;
                            if (int'(w_n) > DEPTH) begin
                                r_state <= ERR;
                                r_error <= 1'b1;
                                r_busy  <= 1'b0;
                            end else if (w_n == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                r_state <= CHK;
`else
                                r_state      <= DONE;
                                r_cpuRestart <= 1'b1;
                                r_busy       <= 1'b0;
`endif
                            end else begin
                                r_state <= DATA;
                            end
                        end else if (w_timeout) begin
                            r_state <= ERR;
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                    DATA: begin
                        if (w_dataByte) begin
                            r_byteCnt <= r_byteCnt + (LEN_W + 2)'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                        end else if (rx_valid && !r_chkHave) begin
                            r_chkHave <= 1'b1;
                            r_chkByte <= rx_data;
`endif
                        end
                        if (w_wordValid && w_lastWord) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            r_state <= CHK;
`else
                            r_state      <= DONE;
                            r_cpuRestart <= 1'b1;
                            r_busy       <= 1'b0;
`endif
                        end else if (w_timeout) begin
                            r_state <= ERR;
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
`ifdef IMEM_LOADER_CHECKSUM_EN
                    CHK: begin
                        if (rx_valid || r_chkHave) begin
                            r_busy <= 1'b0;
                            if (w_chkByte == w_xor) begin
                                r_state      <= DONE;
                                r_cpuRestart <= 1'b1;
                            end else begin
                                r_state <= ERR;
                                r_error <= 1'b1;
                            end
                        end else if (w_timeout) begin
                            r_state <= ERR;
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
`endif
                    DONE: begin
                        r_state   <= RUN;
                        r_cpuHold <= 1'b0;
                    end
                    ERR: begin
                    end
                    default: begin
                        r_state <= RUN;
                    end
                endcase
            end
        end
    end

    assign imem_addr    = r_cpuHold ? r_ptr : cpu_addr;
    assign imem_we      = w_wordValid;
    assign imem_wdata   = w_word;
    assign cpu_hold     = r_cpuHold;
    assign cpu_restart  = r_cpuRestart;
    assign busy         = r_busy;
    assign error        = r_error;
    assign words_loaded = r_wordsLoaded;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader with a write scoreboard.
// Builds with or without IMEM_LOADER_CHECKSUM_EN; checksum-specific cases follow the macro.
module tb_imem_loader;

    localparam int DEPTH       = 256;
    localparam int ADDR_W      = 8;
    localparam int TIMEOUT_CYC = 100;

    logic              clk;
    logic              reset;
    logic              load_req;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [ADDR_W-1:0] cpu_addr;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_we;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              cpu_restart;
    logic              busy;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    int checks = 0;
    int errors = 0;
    int restartCount = 0;
    int expRestart = 0;
    logic [63:0] expQ[$];

    imem_loader #(
        .DEPTH       (DEPTH),
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .load_req     (load_req),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .cpu_addr     (cpu_addr),
        .imem_addr    (imem_addr),
        .imem_we      (imem_we),
        .imem_wdata   (imem_wdata),
        .cpu_hold     (cpu_hold),
        .cpu_restart  (cpu_restart),
        .busy         (busy),
        .error        (error),
        .words_loaded (words_loaded)
    );

    // Free-running 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: count it, and report on a mismatch
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Present one byte for exactly one cycle
    task automatic applyStimulus(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // One-cycle load request
    task automatic pulseLoad();
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Two-word reference frame; the trailing checksum byte is sent only when compiled in
    task automatic sendTwoWordFrame(input logic [7:0] chk);
        logic [7:0] bytesQ[$];
        bytesQ = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        expQ.push_back({32'd0, 32'h12345678});
        expQ.push_back({32'd1, 32'h9ABCDEF0});
        foreach (bytesQ[i]) applyStimulus(bytesQ[i]);
`ifdef IMEM_LOADER_CHECKSUM_EN
        applyStimulus(chk);
`else
        if (chk != 8'h00) $display("[TB] note: checksum byte %0h not sent in this build", chk);
`endif
    endtask

    // Monitor: every memory write is matched against the scoreboard; restart pulses are counted
    always @(negedge clk) begin
        if (!reset && imem_we) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write actual addr=%0h data=%0h required=none", imem_addr, imem_wdata);
            end else begin
                logic [63:0] e;
                e = expQ.pop_front();
                checkOutput("write_addr", 32'(imem_addr), e[63:32]);
                checkOutput("write_data", imem_wdata, e[31:0]);
            end
        end
        if (!reset && cpu_restart) restartCount++;
    end

    // Directed scenarios
    initial begin
        reset    = 1'b1;
        load_req = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        cpu_addr = 8'd5;

        waitCycles(3);
        checkOutput("reset_hold", 32'(cpu_hold), 32'd0);
        checkOutput("reset_addr", 32'(imem_addr), 32'd5);
        checkOutput("reset_we", 32'(imem_we), 32'd0);
        checkOutput("reset_error", 32'(error), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Bytes in RUN are ignored
        applyStimulus(8'h00);
        applyStimulus(8'h01);
        waitCycles(2);
        checkOutput("run_ignores_rx", 32'(cpu_hold), 32'd0);

        // Good two-word load
        pulseLoad();
        @(negedge clk);
        checkOutput("load_hold", 32'(cpu_hold), 32'd1);
        checkOutput("load_busy", 32'(busy), 32'd1);
        checkOutput("load_addr_mux", 32'(imem_addr), 32'd0);
        sendTwoWordFrame(8'h00);
        expRestart++;
        waitCycles(5);
        checkOutput("good_words", 32'(words_loaded), 32'd2);
        checkOutput("good_hold", 32'(cpu_hold), 32'd0);
        checkOutput("good_restart", 32'(restartCount), 32'(expRestart));
        checkOutput("good_error", 32'(error), 32'd0);
        checkOutput("good_addr", 32'(imem_addr), 32'd5);
        checkOutput("good_pending", 32'(expQ.size()), 32'd0);

        // Oversized length goes to ERR and holds the CPU
        pulseLoad();
        applyStimulus(8'h01);
        applyStimulus(8'h01);
        @(negedge clk);
        checkOutput("len_err_error", 32'(error), 32'd1);
        checkOutput("len_err_busy", 32'(busy), 32'd0);
        waitCycles(4);
        checkOutput("len_err_hold", 32'(cpu_hold), 32'd1);
        checkOutput("len_err_words", 32'(words_loaded), 32'd0);

        // Recovery with a fresh request
        pulseLoad();
        @(negedge clk);
        checkOutput("retry_error_clr", 32'(error), 32'd0);
        sendTwoWordFrame(8'h00);
        expRestart++;
        waitCycles(5);
        checkOutput("retry_words", 32'(words_loaded), 32'd2);
        checkOutput("retry_restart", 32'(restartCount), 32'(expRestart));
        checkOutput("retry_hold", 32'(cpu_hold), 32'd0);

        // Zero-length frame restarts without writing
        pulseLoad();
        applyStimulus(8'h00);
        applyStimulus(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
        applyStimulus(8'h00);
`endif
        expRestart++;
        waitCycles(5);
        checkOutput("zero_words", 32'(words_loaded), 32'd0);
        checkOutput("zero_restart", 32'(restartCount), 32'(expRestart));
        checkOutput("zero_hold", 32'(cpu_hold), 32'd0);

        // Timeout after partial data: just short of the limit, then past it
        pulseLoad();
        applyStimulus(8'h00);
        applyStimulus(8'h01);
        applyStimulus(8'h12);
        waitCycles(98);
        checkOutput("timeout_early", 32'(error), 32'd0);
        waitCycles(3);
        checkOutput("timeout_error", 32'(error), 32'd1);
        checkOutput("timeout_hold", 32'(cpu_hold), 32'd1);
        applyStimulus(8'h34);
        applyStimulus(8'h56);
        applyStimulus(8'h78);
        waitCycles(4);
        checkOutput("timeout_words", 32'(words_loaded), 32'd0);
        checkOutput("timeout_sticky", 32'(error), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Bad checksum: data still written, but no restart
        pulseLoad();
        sendTwoWordFrame(8'h01);
        waitCycles(5);
        checkOutput("badchk_error", 32'(error), 32'd1);
        checkOutput("badchk_restart", 32'(restartCount), 32'(expRestart));
        checkOutput("badchk_hold", 32'(cpu_hold), 32'd1);
        pulseLoad();
        sendTwoWordFrame(8'h00);
        expRestart++;
        waitCycles(5);
        checkOutput("goodchk_error", 32'(error), 32'd0);
        checkOutput("goodchk_restart", 32'(restartCount), 32'(expRestart));
`endif

        // Reset in the middle of the second word aborts the load
        pulseLoad();
        expQ.push_back({32'd0, 32'h12345678});
        applyStimulus(8'h00);
        applyStimulus(8'h02);
        applyStimulus(8'h12);
        applyStimulus(8'h34);
        applyStimulus(8'h56);
        applyStimulus(8'h78);
        applyStimulus(8'h9A);
        applyStimulus(8'hBC);
        reset    = 1'b1;
        cpu_addr = 8'd9;
        @(negedge clk);
        checkOutput("abort_hold", 32'(cpu_hold), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_words", 32'(words_loaded), 32'd0);
        checkOutput("abort_we", 32'(imem_we), 32'd0);
        checkOutput("abort_addr", 32'(imem_addr), 32'd9);
        cpu_addr = 8'd17;
        @(negedge clk);
        checkOutput("abort_addr_track", 32'(imem_addr), 32'd17);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        cpu_addr = 8'd3;
        applyStimulus(8'hDE);
        applyStimulus(8'hF0);
        waitCycles(10);
        checkOutput("abort_no_write", 32'(expQ.size()), 32'd0);
        checkOutput("abort_run_addr", 32'(imem_addr), 32'd3);
        checkOutput("abort_restart", 32'(restartCount), 32'(expRestart));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
